conv_window_sequencer: RTL
==========================

# conv_window_sequencer

Sequences the convolution window walk for the `input_coordinate_calc` datapath. After a `start` pulse it iterates every output pixel and every kernel tap. For each step it emits the output and kernel coordinates, the signed input coordinate and a padding flag over a valid/ready stream. It sits between the layer controller and the input-buffer read port; padded taps are flagged so downstream logic can substitute zero.

## Interface

Parameters:
- `ADDR_WIDTH`, 8: width of all unsigned coordinates.
- `IN_H`, 4: input feature-map height.
- `IN_W`, 4: input feature-map width.
- `K`, 3: square kernel size.
- `STRIDE`, 1: convolution stride, ≥1.
- `PADDING`, 1: zero padding per side, < K.
- `OUT_H`, derived: (IN_H + 2·PADDING − K)/STRIDE + 1.
- `OUT_W`, derived: same formula with IN_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin one frame walk; sampled only in IDLE.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse in the DONE state.
- `coord_valid` out 1: current tap is presented.
- `coord_ready` in 1: consumer accepts the tap.
- `out_row`, `out_col` out ADDR_WIDTH: output pixel coordinate.
- `k_row`, `k_col` out ADDR_WIDTH: kernel tap coordinate.
- `in_row`, `in_col` out ADDR_WIDTH+1, signed: out·STRIDE + k − PADDING.
- `pad` out 1: tap lies outside the input map.
- `first` out 1: tap k_row=0, k_col=0 (start of accumulation).
- `last` out 1: tap k_row=K−1, k_col=K−1 (accumulation complete).
- `frame_last` out 1: final tap of the frame.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE on a handshake of the tap with `frame_last`=1.
  - DONE → IDLE unconditionally after 1 cycle.
- Loop order, innermost first: `k_col`, `k_row`, `out_col`, `out_row`. Total taps per frame = OUT_H·OUT_W·K·K.
- Handshake: a tap transfers when `coord_valid` & `coord_ready`. On transfer the counters advance to the next tap.
- While `coord_valid`=1 and `coord_ready`=0, every coordinate and flag output holds stable.
- Counter wrap:
  - `k_col` wraps K−1→0 and carries into `k_row`.
  - `k_row` wraps K−1→0 and carries into `out_col`.
  - `out_col` wraps OUT_W−1→0 and carries into `out_row`.
- Arithmetic:
  - Products and sums are computed at ADDR_WIDTH+2 bits and truncated to signed ADDR_WIDTH+1.
  - `pad` = (`in_row`<0) | (`in_row`≥IN_H) | (`in_col`<0) | (`in_col`≥IN_W).
- `start` while `busy`=1 is ignored; the frame is not restarted.
- `coord_ready` has no effect while `coord_valid`=0.
- Reset, including mid-frame: next state is IDLE, all counters are 0 and any in-flight frame is abandoned without a `done` pulse.

## Timing

- Reset values:
  - `busy`, `done`, `coord_valid`, `pad`, `first`, `last`, `frame_last` = 0.
  - All coordinate outputs = 0.
  - `in_row` and `in_col` = 0 in reset, even though the (0,0,0,0) tap would compute −PADDING.
- All outputs are registered; there is no combinational path from `coord_ready` to any output.
- Start latency: `start` high at edge N → `coord_valid`=1 with tap (0,0,0,0) after edge N+1.
- Throughput is one tap per cycle with `coord_ready` held high. Next tap appears the cycle after each handshake.
- `coord_valid` deasserts on the edge that accepts `frame_last`. `done`=1 for exactly the following cycle. `busy` falls one cycle after `done`.
- Unstalled frame length: 1 + taps + 1 cycles, from `start` to return to IDLE.

## Configuration

- `CONV_SEQ_STALL_CNT_EN` defined:
  - Adds output `stall_count` [15:0], which counts cycles with `coord_valid`=1 and `coord_ready`=0.
  - Clears to 0 on reset and on the IDLE→RUN transition.
  - Saturates at 16'hFFFF.
  - Holds its value after the frame for readback.
- `CONV_SEQ_STALL_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan

- Defaults (4×4 input, K=3, S=1, P=1), `coord_ready`=1: exactly 144 handshakes.
  - First tap: `in_row`=`in_col`=−1, `pad`=1, `first`=1.
  - Tap out(1,1), k(1,1): in(1,1), `pad`=0.
  - Final tap out(3,3), k(2,2): in(4,4), `pad`=1, `last`=1, `frame_last`=1.
  - `done` pulses 1 cycle after the final tap; 146 cycles from start to idle.
- Back-pressure: toggle `coord_ready` pseudo-randomly.
  - Outputs remain stable whenever `coord_ready`=0.
  - Tap sequence is identical to the unstalled run.
  - With the macro defined, `stall_count` equals the number of cycles with `coord_ready`=0 and `coord_valid`=1.
- Stride: IN_H=IN_W=5, K=3, S=2, P=0.
  - 36 taps, `pad` never set.
  - Tap out(1,1), k(2,2): in(4,4) with `frame_last`=1.
- `start` reasserted mid-frame: no restart, tap count stays 144, single `done` pulse.
- `rst_n`=0 for 1 cycle at tap 50: next cycle all outputs are at reset values and there is no `done`. A new `start` replays from tap (0,0,0,0).
- `coord_ready`=0 held for 20 cycles on the first tap: the tap stays presented, then completes normally when `coord_ready` is released.

Source files
------------

// File: rtl/conv_window_sequencer_if.sv
// Tap stream between conv_window_sequencer (master) and the input-buffer read side (slave).
interface conv_window_sequencer_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                         coord_valid;
   logic                         coord_ready;
   logic [ADDR_WIDTH-1:0]        out_row;
   logic [ADDR_WIDTH-1:0]        out_col;
   logic [ADDR_WIDTH-1:0]        k_row;
   logic [ADDR_WIDTH-1:0]        k_col;
   logic signed [ADDR_WIDTH:0]   in_row;
   logic signed [ADDR_WIDTH:0]   in_col;
   logic                         pad;
   logic                         first;
   logic                         last;
   logic                         frame_last;

   modport master (
      output coord_valid, out_row, out_col, k_row, k_col,
             in_row, in_col, pad, first, last, frame_last,
      input  coord_ready
   );

   modport slave (
      input  coord_valid, out_row, out_col, k_row, k_col,
             in_row, in_col, pad, first, last, frame_last,
      output coord_ready
   );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks output pixels and kernel taps of one conv frame, emitting signed input coordinates.
// Optional CONV_SEQ_STALL_CNT_EN adds a saturating back-pressure cycle counter (stall_count).
//
// state | meaning
// IDLE  | waiting for start, all outputs at rest
// RUN   | presenting taps on the coord stream
// DONE  | one-cycle done pulse after the final tap
module conv_window_sequencer #(
   parameter int ADDR_WIDTH = 8,
   parameter int IN_H       = 4,
   parameter int IN_W       = 4,
   parameter int K          = 3,
   parameter int STRIDE     = 1,
   parameter int PADDING    = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
`ifdef CONV_SEQ_STALL_CNT_EN
   output logic [15:0]             stall_count,
`endif
   conv_window_sequencer_if.master coord
);
   localparam int AW    = ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 2;
   localparam int OUT_H = (IN_H + 2 * PADDING - K) / STRIDE + 1;
   localparam int OUT_W = (IN_W + 2 * PADDING - K) / STRIDE + 1;

   localparam logic [AW-1:0]      K_MAX   = AW'(K - 1);
   localparam logic [AW-1:0]      OW_MAX  = AW'(OUT_W - 1);
   localparam logic [AW-1:0]      OH_MAX  = AW'(OUT_H - 1);
   localparam logic signed [AW:0] IN_H_S  = (AW + 1)'(IN_H);
   localparam logic signed [AW:0] IN_W_S  = (AW + 1)'(IN_W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic                busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic [AW-1:0]       orow_q, orow_d, ocol_q, ocol_d, krow_q, krow_d, kcol_q, kcol_d;
   logic signed [AW:0]  in_row_q, in_row_d, in_col_q, in_col_d;
   logic                pad_q, pad_d, first_q, first_d, last_q, last_d, flast_q, flast_d;
   logic                handshake;

   // Wide intermediate so the -PADDING underflow lands correctly in the signed result.
   function automatic logic signed [AW:0] in_coord(input logic [AW-1:0] o, input logic [AW-1:0] k);
      logic [CW-1:0] acc;
      acc = CW'(o) * CW'(STRIDE) + CW'(k) - CW'(PADDING);
      return $signed(acc[AW:0]);
   endfunction

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      orow_d    = orow_q;
      ocol_d    = ocol_q;
      krow_d    = krow_q;
      kcol_d    = kcol_q;
      handshake = valid_q && coord.coord_ready;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               valid_d = 1'b1;
               orow_d  = '0;
               ocol_d  = '0;
               krow_d  = '0;
               kcol_d  = '0;
            end
         end
         RUN: begin
            if (handshake) begin
               if (flast_q) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  orow_d  = '0;
                  ocol_d  = '0;
                  krow_d  = '0;
                  kcol_d  = '0;
               end else if (kcol_q != K_MAX) begin
                  kcol_d = kcol_q + 1'b1;
               end else begin
                  kcol_d = '0;
                  if (krow_q != K_MAX) begin
                     krow_d = krow_q + 1'b1;
                  end else begin
                     krow_d = '0;
                     if (ocol_q != OW_MAX) begin
                        ocol_d = ocol_q + 1'b1;
                     end else begin
                        ocol_d = '0;
                        orow_d = orow_q + 1'b1;
                     end
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);

      // Tap outputs are registered from the next counter values; idle shows zeros.
      in_row_d = '0;
      in_col_d = '0;
      pad_d    = 1'b0;
      first_d  = 1'b0;
      last_d   = 1'b0;
      flast_d  = 1'b0;
      if (valid_d) begin
         in_row_d = in_coord(orow_d, krow_d);
         in_col_d = in_coord(ocol_d, kcol_d);
         pad_d    = in_row_d[AW] || (in_row_d >= IN_H_S) ||
                    in_col_d[AW] || (in_col_d >= IN_W_S);
         first_d  = (krow_d == '0) && (kcol_d == '0);
         last_d   = (krow_d == K_MAX) && (kcol_d == K_MAX);
         flast_d  = last_d && (ocol_d == OW_MAX) && (orow_d == OH_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         orow_q   <= '0;
         ocol_q   <= '0;
         krow_q   <= '0;
         kcol_q   <= '0;
         in_row_q <= '0;
         in_col_q <= '0;
         pad_q    <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         flast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         orow_q   <= orow_d;
         ocol_q   <= ocol_d;
         krow_q   <= krow_d;
         kcol_q   <= kcol_d;
         in_row_q <= in_row_d;
         in_col_q <= in_col_d;
         pad_q    <= pad_d;
         first_q  <= first_d;
         last_q   <= last_d;
         flast_q  <= flast_d;
      end
   end

`ifdef CONV_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == IDLE && start) begin
         stall_cnt_d = '0;
      end else if (valid_q && !coord.coord_ready && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_count = stall_cnt_q;
`endif

   assign busy             = busy_q;
   assign done             = done_q;
   assign coord.coord_valid = valid_q;
   assign coord.out_row    = orow_q;
   assign coord.out_col    = ocol_q;
   assign coord.k_row      = krow_q;
   assign coord.k_col      = kcol_q;
   assign coord.in_row     = in_row_q;
   assign coord.in_col     = in_col_q;
   assign coord.pad        = pad_q;
   assign coord.first      = first_q;
   assign coord.last       = last_q;
   assign coord.frame_last = flast_q;
endmodule
